// File: rtl/vector_beat_sequencer.sv
// Issue-side encoder feeding control_unit: passes instructions through with one
// register of latency, expands vector loads/stores into memory beats and pads branch shadows.
module vector_beat_sequencer #(
  parameter int VEC_BEATS      = 4,
  parameter int BRANCH_BUBBLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_type,
  input  logic [4:0] in_opcode,
  input  logic       flush,
  output logic       in_ready,
  output logic [1:0] out_type,
  output logic [4:0] out_opcode,
  output logic       out_valid,
  output logic       busy
);

  if (VEC_BEATS < 2 || VEC_BEATS > 16) begin : g_bad_vec_beats
    $error("vector_beat_sequencer: VEC_BEATS=%0d outside 2..16", VEC_BEATS);
  end
  if (BRANCH_BUBBLES < 0 || BRANCH_BUBBLES > 15) begin : g_bad_branch_bubbles
    $error("vector_beat_sequencer: BRANCH_BUBBLES=%0d outside 0..15", BRANCH_BUBBLES);
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VREAD  = 2'd1,
    S_VWRITE = 2'd2,
    S_BUBBLE = 2'd3
  } state_t;

  localparam logic [1:0] STALL_TYPE = 2'b01;
  localparam logic [4:0] OP_NOP     = 5'b00101;
  localparam logic [4:0] OP_SREAD   = 5'b00110;
  localparam logic [4:0] OP_SWRITE  = 5'b00111;
  localparam logic [3:0] VEC_CNT    = 4'(VEC_BEATS - 1);
  localparam logic [3:0] BUB_CNT    = 4'(BRANCH_BUBBLES);
  localparam logic       HAS_BUB    = (BRANCH_BUBBLES > 0);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_out_type;
  logic [4:0] r_out_opcode;
  logic       r_out_valid;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic [1:0] w_type_nxt;
  logic [4:0] w_opcode_nxt;
  logic       w_valid_nxt;
  logic       w_accept;
  logic       w_is_vload;
  logic       w_is_vstore;
  logic       w_is_ctrl;

  assign in_ready    = rst && (r_state == S_IDLE) && !flush;
  assign w_accept    = in_valid && in_ready;
  assign w_is_vload  = (in_type == 2'b00) && (in_opcode[4:3] == 2'b10);
  assign w_is_vstore = (in_type == 2'b00) && (in_opcode[4:3] == 2'b11);
  assign w_is_ctrl   = (in_type == 2'b10);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_type_nxt   = STALL_TYPE;
    w_opcode_nxt = OP_NOP;
    w_valid_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_type_nxt   = in_type;
          w_opcode_nxt = in_opcode;
          w_valid_nxt  = 1'b1;
          if (w_is_vload) begin
            w_state_nxt = S_VREAD;
            w_cnt_nxt   = VEC_CNT;
          end else if (w_is_vstore) begin
            w_state_nxt = S_VWRITE;
            w_cnt_nxt   = VEC_CNT;
          end else if (w_is_ctrl && HAS_BUB) begin
            w_state_nxt = S_BUBBLE;
            w_cnt_nxt   = BUB_CNT;
          end
        end
      end
      // Memory beats ignore flush: a started transfer always completes.
      S_VREAD, S_VWRITE: begin
        w_opcode_nxt = (r_state == S_VREAD) ? OP_SREAD : OP_SWRITE;
        w_valid_nxt  = 1'b1;
        w_cnt_nxt    = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_IDLE;
      end
      S_BUBBLE: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1 || flush) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_out_type   <= STALL_TYPE;
      r_out_opcode <= OP_NOP;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out_type   <= w_type_nxt;
      r_out_opcode <= w_opcode_nxt;
      r_out_valid  <= w_valid_nxt;
    end
  end

  assign out_type   = r_out_type;
  assign out_opcode = r_out_opcode;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_vector_beat_sequencer.sv
// Bench for vector_beat_sequencer: directed scenarios then random traffic, all
// compared against a queue of expected output slots built from the issue rules.
module tb_vector_beat_sequencer;

  localparam int VEC_BEATS      = 4;
  localparam int BRANCH_BUBBLES = 2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_type;
  logic [4:0] in_opcode;
  logic       flush;
  logic       in_ready;
  logic [1:0] out_type;
  logic [4:0] out_opcode;
  logic       out_valid;
  logic       busy;

  vector_beat_sequencer #(
    .VEC_BEATS      (VEC_BEATS),
    .BRANCH_BUBBLES (BRANCH_BUBBLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_type    (in_type),
    .in_opcode  (in_opcode),
    .flush      (flush),
    .in_ready   (in_ready),
    .out_type   (out_type),
    .out_opcode (out_opcode),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected output slot; bubbles are the only slots a flush may discard.
  typedef struct packed {
    logic [1:0] t;
    logic [4:0] op;
    logic       v;
    logic       flushable;
  } slot_t;

  slot_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, check the handshake, then the registered output.
  task automatic step(input logic v, input logic [1:0] t, input logic [4:0] op,
                      input logic fl, input string tag);
    slot_t s;
    int    exp_ready;
    in_valid  = v;
    in_type   = t;
    in_opcode = op;
    flush     = fl;
    #1;
    exp_ready = (q.size() == 0 && !fl) ? 1 : 0;
    check({tag, "/in_ready"}, int'(in_ready), exp_ready);
    check({tag, "/busy"}, int'(busy), (q.size() != 0) ? 1 : 0);
    @(posedge clk);
    if (q.size() != 0) begin
      s = q.pop_front();
      if (s.flushable && fl) q.delete();
    end else if (v && exp_ready == 1) begin
      s = '{t: t, op: op, v: 1'b1, flushable: 1'b0};
      if (t == 2'b00 && op[4:3] == 2'b10)
        repeat (VEC_BEATS - 1) q.push_back('{2'b01, 5'b00110, 1'b1, 1'b0});
      else if (t == 2'b00 && op[4:3] == 2'b11)
        repeat (VEC_BEATS - 1) q.push_back('{2'b01, 5'b00111, 1'b1, 1'b0});
      else if (t == 2'b10)
        repeat (BRANCH_BUBBLES) q.push_back('{2'b01, 5'b00101, 1'b0, 1'b1});
    end else begin
      s = '{t: 2'b01, op: 5'b00101, v: 1'b0, flushable: 1'b0};
    end
    @(negedge clk);
    check({tag, "/out_type"}, int'(out_type), int'(s.t));
    check({tag, "/out_opcode"}, int'(out_opcode), int'(s.op));
    check({tag, "/out_valid"}, int'(out_valid), int'(s.v));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/out_type"}, int'(out_type), 1);
    check({tag, "/out_opcode"}, int'(out_opcode), 5);
    check({tag, "/out_valid"}, int'(out_valid), 0);
    check({tag, "/in_ready"}, int'(in_ready), 0);
    check({tag, "/busy"}, int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       h_v;
    logic [1:0] h_t;
    logic [4:0] h_op;
    logic       held;
    logic       fl;
    logic       ready_pred;

    rst = 1'b0; in_valid = 1'b0; in_type = 2'b00; in_opcode = 5'b00000; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Pass-through, back to back.
    step(1'b1, 2'b01, 5'b00000, 1'b0, "plain0");
    step(1'b1, 2'b01, 5'b00011, 1'b0, "plain1");
    step(1'b1, 2'b11, 5'b10101, 1'b0, "plain2");

    // Vector load: instruction, three stall-reads, then the next instruction in slot 5.
    step(1'b1, 2'b00, 5'b10000, 1'b0, "vld");
    repeat (3) step(1'b1, 2'b01, 5'b00001, 1'b0, "vld_beat");
    step(1'b1, 2'b01, 5'b00001, 1'b0, "vld_next");

    // Branch with both bubbles, then with a flush in the first bubble cycle.
    step(1'b1, 2'b10, 5'b01000, 1'b0, "br");
    repeat (2) step(1'b0, 2'b00, 5'b00000, 1'b0, "br_bubble");
    step(1'b1, 2'b10, 5'b01000, 1'b0, "br_fl");
    step(1'b0, 2'b00, 5'b00000, 1'b1, "br_fl_bubble");
    step(1'b0, 2'b00, 5'b00000, 1'b0, "br_fl_after");

    // Flush in IDLE with a valid instruction: not consumed, NOP emitted.
    step(1'b1, 2'b01, 5'b00010, 1'b1, "idle_flush");

    // Flush during the first read beat is ignored.
    step(1'b1, 2'b00, 5'b10110, 1'b0, "vld_fl");
    step(1'b0, 2'b00, 5'b00000, 1'b1, "vld_fl_b1");
    step(1'b0, 2'b00, 5'b00000, 1'b1, "vld_fl_b2");
    step(1'b0, 2'b00, 5'b00000, 1'b0, "vld_fl_b3");
    step(1'b0, 2'b00, 5'b00000, 1'b0, "vld_fl_idle");

    // Vector store interrupted by reset during beat 2.
    step(1'b1, 2'b00, 5'b11000, 1'b0, "vst");
    step(1'b0, 2'b00, 5'b00000, 1'b0, "vst_b1");
    in_valid = 1'b0;
    flush    = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("vst_rst");
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 2'b00, 5'b00000, 1'b0, "vst_rst_idle1");
    step(1'b0, 2'b00, 5'b00000, 1'b0, "vst_rst_idle2");

    // Random traffic; a stalled fetch holds its instruction until accepted.
    held = 1'b0;
    h_v = 1'b0; h_t = 2'b00; h_op = 5'b00000;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 7) == 0);
      if (!held) begin
        h_v  = ($urandom_range(0, 3) != 0);
        h_t  = 2'($urandom);
        h_op = 5'($urandom);
      end
      ready_pred = (q.size() == 0) && !fl;
      step(h_v, h_t, h_op, fl, "rand");
      held = h_v && !ready_pred;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
